// File: rtl/gray_codec_pipe.sv
`default_nettype none
// ============================================================================
// Module  : gray_codec_pipe
// Brief   : Pipelined valid/ready binary<->Gray converter with Gray-stream
//           single-bit adjacency checking and a saturating error counter.
// Revision: 1.0 - initial release
// ============================================================================
module gray_codec_pipe #(
  parameter int         WIDTH   = 8,
  parameter logic [2:0] EN_CODE = 3'b100,
  parameter int         STAGES  = 2,
  parameter int         CNT_W   = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [2:0]       en_i,
  input  logic             mode_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             step_err_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int               c_PCW     = $clog2(WIDTH + 1);
  localparam logic [c_PCW-1:0] c_ONE_BIT = c_PCW'(1);

  logic [WIDTH-1:0]  r_data [STAGES];
  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] r_err;
  logic [WIDTH-1:0]  r_ref;
  logic              r_ref_vld;
  logic [CNT_W-1:0]  r_err_cnt;

  logic [STAGES-1:0] w_adv;
  logic              w_en_ok;
  logic              w_accept;
  logic              w_out_hs;
  logic              w_step_err;
  logic              w_prefix;
  logic [WIDTH-1:0]  w_gray;
  logic [WIDTH-1:0]  w_bin;
  logic [WIDTH-1:0]  w_conv;
  logic [WIDTH-1:0]  w_diff;
  logic [c_PCW-1:0]  w_pop;

  always_comb begin
    w_gray          = '0;
    w_gray[WIDTH-1] = data_i[WIDTH-1];
    for (int i = 0; i < WIDTH - 1; i++) begin
      w_gray[i] = data_i[i] ^ data_i[i+1];
    end
  end

  // Gray->binary is a running XOR from the MSB downwards.
  always_comb begin
    w_prefix = 1'b0;
    w_bin    = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      w_prefix = w_prefix ^ data_i[i];
      w_bin[i] = w_prefix;
    end
  end

  assign w_conv = mode_i ? w_bin : w_gray;
  assign w_diff = data_i ^ r_ref;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + c_PCW'(w_diff[i]);
    end
  end

  // Identical repeats (popcount 0) are errors as well as multi-bit jumps.
  assign w_step_err = mode_i && r_ref_vld && (w_pop != c_ONE_BIT);

  // A stage may load when it is empty or everything downstream moves on.
  always_comb begin
    w_adv           = '0;
    w_adv[STAGES-1] = !r_vld[STAGES-1] || ready_i;
    for (int k = STAGES - 2; k >= 0; k--) begin
      w_adv[k] = !r_vld[k] || w_adv[k+1];
    end
  end

  assign w_en_ok  = (en_i == EN_CODE);
  assign ready_o  = w_en_ok && w_adv[0];
  assign w_accept = valid_i && ready_o;
  assign w_out_hs = r_vld[STAGES-1] && ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_vld     <= '0;
      r_err     <= '0;
      r_ref     <= '0;
      r_ref_vld <= 1'b0;
      r_err_cnt <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_data[k] <= '0;
      end
    end else begin
      if (w_adv[0]) begin
        r_vld[0] <= w_accept;
        r_err[0] <= w_accept && w_step_err;
        if (w_accept) begin
          r_data[0] <= w_conv;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_adv[k]) begin
          r_vld[k]  <= r_vld[k-1];
          r_err[k]  <= r_err[k-1];
          r_data[k] <= r_data[k-1];
        end
      end
      if (w_accept) begin
        if (mode_i) begin
          r_ref     <= data_i;
          r_ref_vld <= 1'b1;
        end else begin
          r_ref_vld <= 1'b0;
        end
      end
      if (w_out_hs && r_err[STAGES-1] && (r_err_cnt != {CNT_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign valid_o    = r_vld[STAGES-1];
  assign data_o     = r_vld[STAGES-1] ? r_data[STAGES-1] : '0;
  assign step_err_o = r_vld[STAGES-1] && r_err[STAGES-1];
  assign err_cnt_o  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gray_codec_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_gray_codec_pipe
// Brief   : Self-checking bench for gray_codec_pipe against a queue-based
//           reference model (item age in pipeline, Gray/binary arithmetic).
// Revision: 1.0 - initial release
// ============================================================================
module tb_gray_codec_pipe;

  localparam int         W       = 8;
  localparam int         STAGES  = 2;
  localparam int         CNT_W   = 8;
  localparam logic [2:0] EN      = 3'b100;
  localparam int         CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n, mode, valid_i, ready_i;
  logic [2:0]       en;
  logic [W-1:0]     data_i;
  logic             ready_o, valid_o, step_err_o;
  logic [W-1:0]     data_o;
  logic [CNT_W-1:0] err_cnt_o;

  gray_codec_pipe #(
    .WIDTH(W), .EN_CODE(EN), .STAGES(STAGES), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .mode_i(mode),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .step_err_o(step_err_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] data; logic err; int age; } item_t;
  typedef struct { logic [W-1:0] data; logic err; } out_t;

  item_t        q[$];
  out_t         outlog[$];
  logic [W-1:0] m_ref;
  bit           m_ref_vld;
  int           m_cnt;
  int           n_checks = 0;
  int           n_fail   = 0;

  function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [W-1:0] to_bin(input logic [W-1:0] g);
    logic [W-1:0] b, t;
    b = '0;
    for (int i = 0; i < W; i++) begin
      t    = g >> i;
      b[i] = ^t;
    end
    return b;
  endfunction

  function automatic logic exp_valid();
    return (q.size() > 0) && (q[0].age >= STAGES - 1);
  endfunction
  function automatic logic [W-1:0] exp_data();
    return exp_valid() ? q[0].data : '0;
  endfunction
  function automatic logic exp_err();
    return exp_valid() ? q[0].err : 1'b0;
  endfunction
  function automatic logic exp_ready();
    return (en == EN) && ((q.size() < STAGES) || ready_i);
  endfunction

  // One clock edge: advances the reference model alongside the DUT.
  task automatic step();
    bit           acc, pop, md;
    logic [W-1:0] d;
    item_t        it;
    out_t         o;
    acc = rst_n && valid_i && exp_ready();
    pop = rst_n && exp_valid() && ready_i;
    md  = mode;
    d   = data_i;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_ref_vld = 0;
      m_cnt     = 0;
    end else begin
      if (pop) begin
        if (q[0].err && m_cnt < CNT_MAX) m_cnt++;
        o.data = q[0].data;
        o.err  = q[0].err;
        outlog.push_back(o);
        void'(q.pop_front());
      end
      foreach (q[i]) q[i].age++;
      if (acc) begin
        it.age = 0;
        if (md) begin
          it.data   = to_bin(d);
          it.err    = m_ref_vld && ($countones(d ^ m_ref) != 1);
          m_ref     = d;
          m_ref_vld = 1;
        end else begin
          it.data   = to_gray(d);
          it.err    = 1'b0;
          m_ref_vld = 0;
        end
        q.push_back(it);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; valid_i = 0; ready_i = 1; en = EN; mode = 0; data_i = '0;
    step();
    step();
    n_checks++;
    if ({valid_o, data_o, step_err_o, err_cnt_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outs got v=%b d=%h e=%b n=%0d exp all zero",
               valid_o, data_o, step_err_o, err_cnt_o);
    end
    #1;
    n_checks++;
    if (ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready got %b exp 1", ready_o);
    end
    rst_n = 1;
  endtask

  task automatic test_b2g();
    int base = outlog.size();
    for (int c = 0; c < 6; c++) begin
      valid_i = (c == 0); mode = 0; data_i = 8'h2D; ready_i = 1; en = EN;
      #1;
      n_checks++;
      if (ready_o !== exp_ready()) begin
        n_fail++;
        $display("FAIL b2g_ready c=%0d got %b exp %b", c, ready_o, exp_ready());
      end
      step();
      n_checks++;
      if (valid_o !== exp_valid() || data_o !== exp_data() ||
          step_err_o !== exp_err() || err_cnt_o !== CNT_W'(m_cnt)) begin
        n_fail++;
        $display("FAIL b2g_out c=%0d got v=%b d=%h e=%b n=%0d exp v=%b d=%h e=%b n=%0d",
                 c, valid_o, data_o, step_err_o, err_cnt_o,
                 exp_valid(), exp_data(), exp_err(), m_cnt);
      end
      if (c == 1) begin
        n_checks++;
        if (valid_o !== 1'b1 || data_o !== 8'h3B) begin
          n_fail++;
          $display("FAIL b2g_latency got v=%b d=%h exp v=1 d=3b", valid_o, data_o);
        end
      end
    end
    n_checks++;
    if (outlog.size() != base + 1 || outlog[base].data !== 8'h3B || outlog[base].err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2g_result got n=%0d exp n=1 d=3b e=0", outlog.size() - base);
    end
  endtask

  task automatic test_g2b();
    logic [W-1:0] vin [3]  = '{8'h3B, 8'hFF, 8'h80};
    logic [W-1:0] vexp [3] = '{8'h2D, 8'hAA, 8'hFF};
    int base = outlog.size();
    for (int c = 0; c < 7; c++) begin
      valid_i = (c < 3); mode = 1; data_i = (c < 3) ? vin[c] : '0; ready_i = 1;
      #1;
      n_checks++;
      if (ready_o !== exp_ready()) begin
        n_fail++;
        $display("FAIL g2b_ready c=%0d got %b exp %b", c, ready_o, exp_ready());
      end
      step();
      n_checks++;
      if (valid_o !== exp_valid() || data_o !== exp_data() ||
          step_err_o !== exp_err() || err_cnt_o !== CNT_W'(m_cnt)) begin
        n_fail++;
        $display("FAIL g2b_out c=%0d got v=%b d=%h e=%b n=%0d exp v=%b d=%h e=%b n=%0d",
                 c, valid_o, data_o, step_err_o, err_cnt_o,
                 exp_valid(), exp_data(), exp_err(), m_cnt);
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (outlog.size() <= base + i || outlog[base+i].data !== vexp[i]) begin
        n_fail++;
        $display("FAIL g2b_value idx=%0d exp %h", i, vexp[i]);
      end
    end
  endtask

  task automatic test_adjacency();
    logic [W-1:0] vin [8] = '{8'h00, 8'h00, 8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h55};
    bit           vmd [8] = '{0, 1, 1, 1, 1, 1, 0, 1};
    bit           verr [8] = '{0, 0, 0, 0, 1, 1, 0, 0};
    int base  = outlog.size();
    int cnt0  = m_cnt;
    for (int c = 0; c < 12; c++) begin
      valid_i = (c < 8); mode = (c < 8) ? vmd[c] : 1'b0;
      data_i = (c < 8) ? vin[c] : '0; ready_i = 1;
      #1;
      n_checks++;
      if (ready_o !== exp_ready()) begin
        n_fail++;
        $display("FAIL adj_ready c=%0d got %b exp %b", c, ready_o, exp_ready());
      end
      step();
      n_checks++;
      if (valid_o !== exp_valid() || data_o !== exp_data() ||
          step_err_o !== exp_err() || err_cnt_o !== CNT_W'(m_cnt)) begin
        n_fail++;
        $display("FAIL adj_out c=%0d got v=%b d=%h e=%b n=%0d exp v=%b d=%h e=%b n=%0d",
                 c, valid_o, data_o, step_err_o, err_cnt_o,
                 exp_valid(), exp_data(), exp_err(), m_cnt);
      end
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (outlog.size() <= base + i || outlog[base+i].err !== verr[i]) begin
        n_fail++;
        $display("FAIL adj_err idx=%0d exp %b", i, verr[i]);
      end
    end
    n_checks++;
    if (err_cnt_o !== CNT_W'(cnt0 + 2)) begin
      n_fail++;
      $display("FAIL adj_cnt got %0d exp %0d", err_cnt_o, cnt0 + 2);
    end
  endtask

  task automatic test_enable();
    int base = outlog.size();
    for (int c = 0; c < 10; c++) begin
      en = (c >= 1 && c <= 4) ? 3'b101 : EN;
      valid_i = (c <= 5); mode = 0; data_i = (c == 0) ? 8'h20 : 8'h10; ready_i = 1;
      #1;
      n_checks++;
      if (ready_o !== exp_ready() || (c >= 1 && c <= 4 && ready_o !== 1'b0)) begin
        n_fail++;
        $display("FAIL en_ready c=%0d got %b exp %b", c, ready_o, exp_ready());
      end
      step();
      n_checks++;
      if (valid_o !== exp_valid() || data_o !== exp_data() ||
          step_err_o !== exp_err() || err_cnt_o !== CNT_W'(m_cnt)) begin
        n_fail++;
        $display("FAIL en_out c=%0d got v=%b d=%h e=%b n=%0d exp v=%b d=%h e=%b n=%0d",
                 c, valid_o, data_o, step_err_o, err_cnt_o,
                 exp_valid(), exp_data(), exp_err(), m_cnt);
      end
    end
    n_checks++;
    if (outlog.size() != base + 2 || outlog[base].data !== 8'h30 || outlog[base+1].data !== 8'h18) begin
      n_fail++;
      $display("FAIL en_result got n=%0d exp n=2 d=30,18", outlog.size() - base);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] vexp [6] = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05};
    int base = outlog.size();
    int idx  = 0;
    for (int c = 0; c < 20; c++) begin
      valid_i = (idx < 6); mode = 0; data_i = W'(idx + 1);
      ready_i = !(c >= 2 && c <= 7); en = EN;
      #1;
      n_checks++;
      if (ready_o !== exp_ready() || (c == 2 && ready_o !== 1'b0)) begin
        n_fail++;
        $display("FAIL bp_ready c=%0d got %b exp %b", c, ready_o, exp_ready());
      end
      if (valid_i && exp_ready()) idx++;
      step();
      n_checks++;
      if (valid_o !== exp_valid() || data_o !== exp_data() ||
          step_err_o !== exp_err() || err_cnt_o !== CNT_W'(m_cnt)) begin
        n_fail++;
        $display("FAIL bp_out c=%0d got v=%b d=%h e=%b n=%0d exp v=%b d=%h e=%b n=%0d",
                 c, valid_o, data_o, step_err_o, err_cnt_o,
                 exp_valid(), exp_data(), exp_err(), m_cnt);
      end
    end
    n_checks++;
    if (outlog.size() != base + 6) begin
      n_fail++;
      $display("FAIL bp_count got %0d exp 6", outlog.size() - base);
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (outlog.size() <= base + i || outlog[base+i].data !== vexp[i]) begin
        n_fail++;
        $display("FAIL bp_order idx=%0d exp %h", i, vexp[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      en      = ($urandom_range(0, 7) == 0) ? 3'($urandom) : EN;
      valid_i = ($urandom_range(0, 9) < 7);
      ready_i = ($urandom_range(0, 9) < 7);
      mode    = $urandom_range(0, 1);
      data_i  = (mode && $urandom_range(0, 3) != 0) ?
                (m_ref ^ (W'(1) << $urandom_range(0, W - 1))) : W'($urandom);
      #1;
      n_checks++;
      if (ready_o !== exp_ready()) begin
        n_fail++;
        $display("FAIL rnd_ready c=%0d got %b exp %b", c, ready_o, exp_ready());
      end
      step();
      n_checks++;
      if (valid_o !== exp_valid() || data_o !== exp_data() ||
          step_err_o !== exp_err() || err_cnt_o !== CNT_W'(m_cnt)) begin
        n_fail++;
        $display("FAIL rnd_out c=%0d got v=%b d=%h e=%b n=%0d exp v=%b d=%h e=%b n=%0d",
                 c, valid_o, data_o, step_err_o, err_cnt_o,
                 exp_valid(), exp_data(), exp_err(), m_cnt);
      end
    end
  endtask

  task automatic test_saturate();
    for (int c = 0; c < 275; c++) begin
      en = EN; valid_i = (c < 270); mode = 1; data_i = 8'h00; ready_i = 1;
      #1;
      n_checks++;
      if (ready_o !== exp_ready()) begin
        n_fail++;
        $display("FAIL sat_ready c=%0d got %b exp %b", c, ready_o, exp_ready());
      end
      step();
      n_checks++;
      if (valid_o !== exp_valid() || data_o !== exp_data() ||
          step_err_o !== exp_err() || err_cnt_o !== CNT_W'(m_cnt)) begin
        n_fail++;
        $display("FAIL sat_out c=%0d got v=%b d=%h e=%b n=%0d exp v=%b d=%h e=%b n=%0d",
                 c, valid_o, data_o, step_err_o, err_cnt_o,
                 exp_valid(), exp_data(), exp_err(), m_cnt);
      end
    end
    n_checks++;
    if (err_cnt_o !== CNT_W'(CNT_MAX)) begin
      n_fail++;
      $display("FAIL sat_cnt got %0d exp %0d", err_cnt_o, CNT_MAX);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    rst_n = 0; valid_i = 0;
    step();
    rst_n = 1;
    for (int c = 0; c < 14; c++) begin
      rst_n   = (c != 9);
      valid_i = (c < 4) || (c == 7) || (c == 8) || (c == 10);
      mode    = 1;
      data_i  = (c == 10) ? 8'hA5 : 8'h00;
      ready_i = !(c >= 7 && c <= 9);
      if (c == 10) base = outlog.size();
      #1;
      n_checks++;
      if (ready_o !== exp_ready()) begin
        n_fail++;
        $display("FAIL rstm_ready c=%0d got %b exp %b", c, ready_o, exp_ready());
      end
      step();
      n_checks++;
      if (valid_o !== exp_valid() || data_o !== exp_data() ||
          step_err_o !== exp_err() || err_cnt_o !== CNT_W'(m_cnt)) begin
        n_fail++;
        $display("FAIL rstm_out c=%0d got v=%b d=%h e=%b n=%0d exp v=%b d=%h e=%b n=%0d",
                 c, valid_o, data_o, step_err_o, err_cnt_o,
                 exp_valid(), exp_data(), exp_err(), m_cnt);
      end
      if (c == 6 || c == 8) begin
        n_checks++;
        if (err_cnt_o !== 8'd3) begin
          n_fail++;
          $display("FAIL rstm_precnt c=%0d got %0d exp 3", c, err_cnt_o);
        end
      end
      if (c == 9) begin
        n_checks++;
        if ({valid_o, data_o, err_cnt_o} !== '0) begin
          n_fail++;
          $display("FAIL rstm_cleared got v=%b d=%h n=%0d exp 0,00,0", valid_o, data_o, err_cnt_o);
        end
      end
    end
    n_checks++;
    if (outlog.size() != base + 1 || outlog[base].data !== 8'hC6 || outlog[base].err !== 1'b0) begin
      n_fail++;
      $display("FAIL rstm_first_gray got n=%0d exp n=1 d=c6 e=0", outlog.size() - base);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_ref = '0; m_ref_vld = 0; m_cnt = 0;
    rst_n = 0; en = EN; mode = 0; valid_i = 0; ready_i = 1; data_i = '0;
    test_reset();
    test_b2g();
    test_g2b();
    test_adjacency();
    test_enable();
    test_backpressure();
    test_random();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
